inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000; the first fetch address after reset.
REQ-002 SHALL have clk  input  1  clock; all state SHALL update on posedge clk.
REQ-003 SHALL have resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have jbr_bus  input  33  {jbr_taken, jbr_target[31:0]} from decode.
REQ-005 SHALL have exc_bus  input  33  {exc_valid, exc_pc[31:0]} from write-back.
REQ-006 SHALL have cancel  input  1  write-back cancel; flushes fetch.
REQ-007 SHALL have ID_allow_in  input  1  decode can accept an instruction this cycle.
REQ-008 SHALL have inst_rom_data  input  32  synchronous ROM read data, valid one cycle after address.
REQ-009 SHALL have inst_addr  output  32  ROM address, equal to current pc register.
REQ-010 SHALL have inst_rom_en  output  1  ROM read enable.
REQ-011 SHALL have IF_over  output  1  instruction in IF is valid and ready to hand off.
REQ-012 SHALL have IF_ID_bus  output  64  {pc[31:0], inst[31:0]} to decode.
REQ-013 SHALL have IF_pc  output  32  display copy of pc.

Function
REQ-014 SHALL implement FSM states S_REQ (address issued, waiting for ROM), S_DATA (ROM data valid), S_HOLD (instruction held in buffer).
REQ-015 S_REQ SHALL transition to S_DATA unconditionally after one cycle; IF_over=0 in S_REQ.
REQ-016 In S_DATA and S_HOLD, IF_over SHALL be 1.
REQ-017 Handoff SHALL occur on a cycle with IF_over=1 and ID_allow_in=1; on handoff pc <= next_pc and state <= S_REQ.
REQ-018 next_pc priority SHALL be: pending jump target, then jbr_target if jbr_taken, then pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 -> 0).
REQ-019 jbr_taken asserted on a non-handoff cycle SHALL be latched into a pending-jump register (valid+target) and consumed and cleared at the next handoff; a later jbr_taken before consumption SHALL overwrite it.
REQ-020 exc_valid & cancel SHALL override everything in the same cycle: pc <= exc_pc, state <= S_REQ, pending jump cleared, buffer invalidated, no handoff counted (IF_over forced 0 that cycle).
REQ-021 cancel without exc_valid SHALL flush to S_REQ re-fetching the current pc, pending jump cleared.
REQ-022 IF_ID_bus SHALL be {pc, inst}, inst = buffer in S_HOLD, inst_rom_data in S_DATA, 32'd0 when IF_over=0.
REQ-023 IF_pc SHALL equal pc; inst_addr SHALL equal pc.
REQ-024 Every instruction fetched SHALL be handed off exactly once unless flushed by REQ-020/021.

Reset
REQ-025 On resetn=0 at posedge clk: pc=RESET_PC, state=S_REQ, pending jump cleared, buffer invalid and 32'd0.
REQ-026 Reset-state outputs: inst_addr=IF_pc=RESET_PC, IF_over=0, IF_ID_bus={RESET_PC,32'd0}, inst_rom_en=1.
REQ-027 Reset asserted mid-operation SHALL discard any pending jump, buffered instruction or in-flight fetch; first fetch after release SHALL be RESET_PC.

Configuration
REQ-028 Macro FETCH_INST_BUF_EN SHALL select stall handling.
REQ-029 With FETCH_INST_BUF_EN defined: S_DATA with ID_allow_in=0 SHALL capture inst_rom_data into the buffer and enter S_HOLD; inst_rom_en=0 in S_HOLD; S_HOLD exits only on handoff or flush.
REQ-030 Without FETCH_INST_BUF_EN: S_HOLD SHALL be unreachable; stall SHALL remain in S_DATA with inst_addr held stable and inst_rom_en=1 every cycle; the buffer register SHALL not be instantiated.
REQ-031 Externally visible handoff sequence (pc/inst pairs) SHALL be identical in both configurations.

Verification
REQ-032 Reset, ID_allow_in=1, ROM[a]=a -> handoffs {0,0},{4,4},{8,8} every 2 cycles, IF_over pattern 0,1,0,1.
REQ-033 Handoff of pc=0x10 with jbr_bus={1,0x40} in same cycle -> next handoff pc=0x40, then 0x44.
REQ-034 jbr_bus={1,0x80} while ID_allow_in=0 at pc=0x20 (S_DATA), stall 3 cycles -> pc 0x20 handed off once, next pc=0x80; with FETCH_INST_BUF_EN, inst_rom_en=0 for 2 stall cycles.
REQ-035 exc_bus={1,0x0} & cancel while in S_HOLD at pc=0x30 with pending jump -> IF_over=0 that cycle, next handoff pc=0x0, pending jump discarded, 0x30 never handed off.
REQ-036 resetn=0 one cycle while pc=0x100 in S_DATA -> next cycle pc=RESET_PC, IF_over=0, IF_ID_bus={RESET_PC,0}.
REQ-037 pc=32'hFFFF_FFFC handoff -> next pc=0x0.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- instruction fetch stage with a synchronous instruction ROM.
//
// A fetch takes two cycles: S_REQ presents pc to the ROM, and S_DATA sees the
// returned word. The instruction is handed to decode on a cycle where IF_over
// and ID_allow_in are both high.
//
// Jumps from decode that arrive while no handoff is taking place are parked in
// a pending-jump register. The parked jump wins over any later redirect at the
// next handoff.
//
// A write-back cancel flushes the stage. If exc_valid is also set, the flush
// redirects to exc_pc. Otherwise the current pc is fetched again.
//
// Configuration macro: FETCH_INST_BUF_EN
//   defined   : a decode stall in S_DATA copies the ROM word into a holding
//               buffer (state S_HOLD), and the ROM enable is dropped while
//               the stall lasts.
//   undefined : the stage waits in S_DATA with the address held steady and the
//               ROM enable kept high, so the ROM keeps returning the same
//               word. No buffer register exists in this build.
//
// Both builds hand decode the same sequence of pc/inst pairs.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [32:0] jbr_bus,
  input  logic [32:0] exc_bus,
  input  logic        cancel,
  input  logic        ID_allow_in,
  input  logic [31:0] inst_rom_data,
  output logic [31:0] inst_addr,
  output logic        inst_rom_en,
  output logic        IF_over,
  output logic [63:0] IF_ID_bus,
  output logic [31:0] IF_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DATA = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  logic [31:0] pc_r;
  logic        jmp_valid_r;
  logic [31:0] jmp_target_r;

  logic        jbr_taken_s;
  logic [31:0] jbr_target_s;
  logic        exc_valid_s;
  logic [31:0] exc_pc_s;
  logic        flush_exc_s;
  logic        handoff_s;
  logic [31:0] next_pc_s;
  logic [31:0] inst_sel_s;

`ifdef FETCH_INST_BUF_EN
  logic [31:0] buf_r;
`endif

  // Split the incoming buses.
  assign jbr_taken_s  = jbr_bus[32];
  assign jbr_target_s = jbr_bus[31:0];
  assign exc_valid_s  = exc_bus[32];
  assign exc_pc_s     = exc_bus[31:0];

  // A cancel that carries an exception redirects. A plain cancel re-fetches.
  assign flush_exc_s  = exc_valid_s & cancel;

  // A handoff needs a valid instruction and a free decode slot. IF_over is
  // already forced low by any cancel.
  assign handoff_s    = IF_over & ID_allow_in;

  // A parked jump beats a jump that arrives on the same cycle, which in turn
  // beats the sequential address. The +4 wraps at 32 bits.
  assign next_pc_s    = jmp_valid_r ? jmp_target_r :
                        (jbr_taken_s ? jbr_target_s : (pc_r + 32'd4));

  // The ROM address and the display pc both come straight from the pc register.
  assign inst_addr    = pc_r;
  assign IF_pc        = pc_r;

  // FSM state register, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= S_REQ;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state. A flush or a handoff always restarts the fetch in S_REQ.
  always_comb begin
    state_nxt_s = state_r;
    if (cancel) begin
      state_nxt_s = S_REQ;
    end else if (handoff_s) begin
      state_nxt_s = S_REQ;
    end else begin
      case (state_r)
        S_REQ: begin
          state_nxt_s = S_DATA;
        end
        S_DATA: begin
          // Reaching this branch means decode is stalled.
`ifdef FETCH_INST_BUF_EN
          state_nxt_s = S_HOLD;
`else
          state_nxt_s = S_DATA;
`endif
        end
        S_HOLD: begin
`ifdef FETCH_INST_BUF_EN
          state_nxt_s = S_HOLD;
`else
          // This state cannot be reached in this build. Fall back to a fresh
          // fetch in case it is ever entered.
          state_nxt_s = S_REQ;
`endif
        end
        default: begin
          state_nxt_s = S_REQ;
        end
      endcase
    end
  end

  // FSM outputs: the valid flag, the ROM enable and the instruction source.
  always_comb begin
    IF_over     = 1'b0;
    inst_rom_en = 1'b1;
    inst_sel_s  = 32'd0;
    case (state_r)
      S_REQ: begin
        IF_over     = 1'b0;
        inst_rom_en = 1'b1;
        inst_sel_s  = 32'd0;
      end
      S_DATA: begin
        IF_over     = ~cancel;
        inst_rom_en = 1'b1;
        inst_sel_s  = inst_rom_data;
      end
      S_HOLD: begin
`ifdef FETCH_INST_BUF_EN
        IF_over     = ~cancel;
        inst_rom_en = 1'b0;
        inst_sel_s  = buf_r;
`else
        IF_over     = 1'b0;
        inst_rom_en = 1'b1;
        inst_sel_s  = 32'd0;
`endif
      end
      default: begin
        IF_over     = 1'b0;
        inst_rom_en = 1'b1;
        inst_sel_s  = 32'd0;
      end
    endcase
    if (IF_over) begin
      IF_ID_bus = {pc_r, inst_sel_s};
    end else begin
      IF_ID_bus = {pc_r, 32'd0};
    end
  end

  // Program counter: reset, then an exception redirect, then a re-fetch on a
  // plain cancel, then an advance on handoff.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_r <= RESET_PC;
    end else if (flush_exc_s) begin
      pc_r <= exc_pc_s;
    end else if (cancel) begin
      pc_r <= pc_r;
    end else if (handoff_s) begin
      pc_r <= next_pc_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Pending jump: set by a jump that arrives with no handoff, used and cleared
  // at the next handoff, and dropped on any flush. A newer jump replaces an
  // older one.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      jmp_valid_r  <= 1'b0;
      jmp_target_r <= 32'd0;
    end else if (cancel) begin
      jmp_valid_r  <= 1'b0;
      jmp_target_r <= 32'd0;
    end else if (handoff_s) begin
      jmp_valid_r  <= 1'b0;
      jmp_target_r <= 32'd0;
    end else if (jbr_taken_s) begin
      jmp_valid_r  <= 1'b1;
      jmp_target_r <= jbr_target_s;
    end else begin
      jmp_valid_r  <= jmp_valid_r;
      jmp_target_r <= jmp_target_r;
    end
  end

`ifdef FETCH_INST_BUF_EN
  // Holding buffer: copies the ROM word when decode stalls in S_DATA, and is
  // cleared on reset and on flush.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      buf_r <= 32'd0;
    end else if (cancel) begin
      buf_r <= 32'd0;
    end else if ((state_r == S_DATA) && !ID_allow_in) begin
      buf_r <= inst_rom_data;
    end else begin
      buf_r <= buf_r;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch -- directed bench for inst_fetch.
// The bench models a synchronous ROM whose word at each address equals that
// address.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk;
  logic        resetn;
  logic [32:0] jbr_bus;
  logic [32:0] exc_bus;
  logic        cancel;
  logic        ID_allow_in;
  logic [31:0] inst_rom_data;
  logic [31:0] inst_addr;
  logic        inst_rom_en;
  logic        IF_over;
  logic [63:0] IF_ID_bus;
  logic [31:0] IF_pc;

  int total;
  int bad;

  logic stall_en_exp;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .jbr_bus       (jbr_bus),
    .exc_bus       (exc_bus),
    .cancel        (cancel),
    .ID_allow_in   (ID_allow_in),
    .inst_rom_data (inst_rom_data),
    .inst_addr     (inst_addr),
    .inst_rom_en   (inst_rom_en),
    .IF_over       (IF_over),
    .IF_ID_bus     (IF_ID_bus),
    .IF_pc         (IF_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model: data at address a is a, returned one cycle later.
  initial inst_rom_data = 32'd0;
  always @(posedge clk) begin
    if (inst_rom_en) inst_rom_data <= inst_addr;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
`ifdef FETCH_INST_BUF_EN
    stall_en_exp = 1'b0;
`else
    stall_en_exp = 1'b1;
`endif
    resetn      = 1'b0;
    jbr_bus     = 33'd0;
    exc_bus     = 33'd0;
    cancel      = 1'b0;
    ID_allow_in = 1'b1;
    tick;
    tick;
    resetn = 1'b1;
    #1;
    // Reset state
    chk("rst_addr",   {32'd0, inst_addr},   64'd0);
    chk("rst_ifpc",   {32'd0, IF_pc},       64'd0);
    chk("rst_over",   {63'd0, IF_over},     64'd0);
    chk("rst_bus",    IF_ID_bus,            64'd0);
    chk("rst_rom_en", {63'd0, inst_rom_en}, 64'd1);

    // Sequential fetch: handoffs {0,0},{4,4},{8,8}, IF_over 0,1,0,1
    tick;
    chk("seq_over0", {63'd0, IF_over}, 64'd1);
    chk("seq_bus0",  IF_ID_bus, {32'h0, 32'h0});
    tick;
    chk("seq_over1", {63'd0, IF_over}, 64'd0);
    chk("seq_req4",  IF_ID_bus, {32'h4, 32'h0});
    chk("seq_addr4", {32'd0, inst_addr}, 64'h4);
    tick;
    chk("seq_bus4",  IF_ID_bus, {32'h4, 32'h4});
    chk("seq_over2", {63'd0, IF_over}, 64'd1);
    tick;
    tick;
    chk("seq_bus8",  IF_ID_bus, {32'h8, 32'h8});
    tick;
    tick;
    tick;
    tick;
    // In S_DATA at 0x10: a jump arrives on the handoff cycle
    jbr_bus = {1'b1, 32'h40};
    #1;
    chk("jmp_bus10", IF_ID_bus, {32'h10, 32'h10});
    tick;
    jbr_bus = 33'd0;
    chk("jmp_addr40", {32'd0, inst_addr}, 64'h40);
    tick;
    chk("jmp_bus40", IF_ID_bus, {32'h40, 32'h40});
    tick;
    chk("jmp_addr44", {32'd0, inst_addr}, 64'h44);
    tick;
    jbr_bus = {1'b1, 32'h20};
    tick;
    jbr_bus = 33'd0;
    tick;
    // In S_DATA at 0x20: stall for three cycles while a jump to 0x80 arrives
    ID_allow_in = 1'b0;
    jbr_bus     = {1'b1, 32'h80};
    #1;
    chk("stl_bus0", IF_ID_bus, {32'h20, 32'h20});
    chk("stl_en0",  {63'd0, inst_rom_en}, 64'd1);
    tick;
    jbr_bus = 33'd0;
    chk("stl_addr1", {32'd0, inst_addr}, 64'h20);
    chk("stl_over1", {63'd0, IF_over}, 64'd1);
    chk("stl_bus1",  IF_ID_bus, {32'h20, 32'h20});
    chk("stl_en1",   {63'd0, inst_rom_en}, {63'd0, stall_en_exp});
    tick;
    chk("stl_bus2",  IF_ID_bus, {32'h20, 32'h20});
    chk("stl_en2",   {63'd0, inst_rom_en}, {63'd0, stall_en_exp});
    tick;
    ID_allow_in = 1'b1;
    #1;
    chk("stl_bus3",  IF_ID_bus, {32'h20, 32'h20});
    tick;
    chk("stl_addr80", {32'd0, inst_addr}, 64'h80);
    chk("stl_over80", {63'd0, IF_over}, 64'd0);
    tick;
    chk("stl_bus80", IF_ID_bus, {32'h80, 32'h80});
    tick;
    chk("stl_addr84", {32'd0, inst_addr}, 64'h84);

    // A jump to 0x30 parked during S_REQ is used at the next handoff
    jbr_bus = {1'b1, 32'h30};
    tick;
    jbr_bus = 33'd0;
    tick;
    chk("pend_addr30", {32'd0, inst_addr}, 64'h30);
    tick;
    ID_allow_in = 1'b0;
    jbr_bus     = {1'b1, 32'h90};
    tick;
    // Stalled at 0x30 with a jump to 0x90 pending: exception with cancel
    jbr_bus     = 33'd0;
    exc_bus     = {1'b1, 32'h0};
    cancel      = 1'b1;
    ID_allow_in = 1'b1;
    #1;
    chk("exc_over", {63'd0, IF_over}, 64'd0);
    chk("exc_bus",  IF_ID_bus, {32'h30, 32'h0});
    tick;
    exc_bus = 33'd0;
    cancel  = 1'b0;
    chk("exc_addr0", {32'd0, inst_addr}, 64'h0);
    chk("exc_over0", {63'd0, IF_over}, 64'd0);
    tick;
    chk("exc_bus0",  IF_ID_bus, {32'h0, 32'h0});
    tick;
    chk("exc_addr4", {32'd0, inst_addr}, 64'h4);

    // Plain cancel in S_DATA re-fetches the same pc
    tick;
    cancel = 1'b1;
    #1;
    chk("cnl_over", {63'd0, IF_over}, 64'd0);
    tick;
    cancel = 1'b0;
    chk("cnl_addr", {32'd0, inst_addr}, 64'h4);
    chk("cnl_over1", {63'd0, IF_over}, 64'd0);
    tick;
    chk("cnl_bus", IF_ID_bus, {32'h4, 32'h4});
    jbr_bus = {1'b1, 32'h100};
    tick;
    jbr_bus = 33'd0;
    chk("rr_addr100", {32'd0, inst_addr}, 64'h100);
    tick;
    chk("rr_bus100", IF_ID_bus, {32'h100, 32'h100});
    // Reset mid-operation in S_DATA, with a jump presented at the same time
    resetn      = 1'b0;
    ID_allow_in = 1'b0;
    jbr_bus     = {1'b1, 32'h200};
    tick;
    resetn      = 1'b1;
    ID_allow_in = 1'b1;
    jbr_bus     = 33'd0;
    #1;
    chk("rr_addr", {32'd0, inst_addr}, 64'h0);
    chk("rr_ifpc", {32'd0, IF_pc}, 64'h0);
    chk("rr_over", {63'd0, IF_over}, 64'd0);
    chk("rr_bus",  IF_ID_bus, 64'd0);
    tick;
    chk("rr_bus0", IF_ID_bus, {32'h0, 32'h0});
    tick;
    chk("rr_addr4", {32'd0, inst_addr}, 64'h4);

    // Wrap from 0xFFFF_FFFC to 0
    jbr_bus = {1'b1, 32'hFFFF_FFFC};
    tick;
    jbr_bus = 33'd0;
    tick;
    chk("wrap_addr", {32'd0, inst_addr}, {32'd0, 32'hFFFF_FFFC});
    tick;
    chk("wrap_bus",  IF_ID_bus, {32'hFFFF_FFFC, 32'hFFFF_FFFC});
    tick;
    chk("wrap_addr0", {32'd0, inst_addr}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
